// File: rtl/rs_syndrome_checker_if.sv
// Stream and status bundle of the RS(255,223) syndrome checker.
// "master" is the upstream/downstream environment side and "slave" is the checker side.
interface rs_syndrome_checker_if;
   logic         s_axis_valid;
   logic         s_axis_ready;
   logic [7:0]   s_axis_data;
   logic         s_axis_last;
   logic         m_axis_valid;
   logic         m_axis_ready;
   logic [7:0]   m_axis_data;
   logic         m_axis_sop;
   logic         m_axis_last;
   logic         st_valid;
   logic         st_ready;
   logic         st_err;
   logic         st_len_err;
   logic [255:0] st_syndromes;

   modport slave (
      input  s_axis_valid, s_axis_data, s_axis_last, m_axis_ready, st_ready,
      output s_axis_ready, m_axis_valid, m_axis_data, m_axis_sop, m_axis_last,
      output st_valid, st_err, st_len_err, st_syndromes
   );

   modport master (
      output s_axis_valid, s_axis_data, s_axis_last, m_axis_ready, st_ready,
      input  s_axis_ready, m_axis_valid, m_axis_data, m_axis_sop, m_axis_last,
      input  st_valid, st_err, st_len_err, st_syndromes
   );
endinterface

// File: rtl/rs_syndrome_checker.sv
// RS(255,223) receive-side syndrome checker: forwards data bytes with zero latency,
// absorbs parity, and reports the 32 syndromes plus error flags after each codeword.
module rs_syndrome_checker #(
   parameter int N_BYTES      = 255,
   parameter int K_BYTES      = 223,
   parameter int PARITY_BYTES = 32,
   parameter int ROOT_BASE    = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rs_syndrome_checker_if.slave bus
);

   localparam logic [7:0] DATA_LAST_IDX = 8'(K_BYTES - 1);
   localparam logic [7:0] CW_LAST_IDX   = 8'(N_BYTES - 1);

   typedef enum logic [1:0] {
      ST_DATA   = 2'd0,
      ST_PARITY = 2'd1,
      ST_STATUS = 2'd2
   } state_t;

   // GF(2^8) multiply over x^8+x^4+x^3+x^2+1; with one constant operand it folds to an XOR network.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            p = p ^ aa;
         end else begin
            p = p;
         end
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1D) : {aa[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_pow(input int e);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < (e % 255); i++) begin
         r = gf_mul(r, 8'h02);
      end
      return r;
   endfunction

   state_t                        state_r;
   state_t                        state_next_s;
   logic [7:0]                    byte_cnt_r;
   logic                          len_err_r;
   logic [PARITY_BYTES*8-1:0]     syn_r;
   logic [PARITY_BYTES*8-1:0]     syn_next_s;

   logic s_ready_s;
   logic m_valid_s;
   logic m_sop_s;
   logic m_last_s;
   logic st_valid_s;
   logic accept_s;
   logic st_hs_s;

   assign accept_s = bus.s_axis_valid && s_ready_s;
   assign st_hs_s  = st_valid_s && bus.st_ready;

   for (genvar j = 0; j < PARITY_BYTES; j++) begin : g_syn
      localparam logic [7:0] ROOT = gf_pow(ROOT_BASE + j);
      assign syn_next_s[8*j +: 8] = gf_mul(syn_r[8*j +: 8], ROOT) ^ bus.s_axis_data;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_DATA;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic; block boundaries come from byte_cnt only, never from s_axis_last
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_DATA: begin
            if (accept_s && (byte_cnt_r == DATA_LAST_IDX)) begin
               state_next_s = ST_PARITY;
            end else begin
               state_next_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (accept_s && (byte_cnt_r == CW_LAST_IDX)) begin
               state_next_s = ST_STATUS;
            end else begin
               state_next_s = ST_PARITY;
            end
         end
         ST_STATUS: begin
            if (bus.st_ready) begin
               state_next_s = ST_DATA;
            end else begin
               state_next_s = ST_STATUS;
            end
         end
         default: state_next_s = ST_DATA;
      endcase
   end

   // FSM outputs: data phase is a pure combinational pass-through of the handshake
   always_comb begin
      s_ready_s  = 1'b0;
      m_valid_s  = 1'b0;
      m_sop_s    = 1'b0;
      m_last_s   = 1'b0;
      st_valid_s = 1'b0;
      case (state_r)
         ST_DATA: begin
            s_ready_s = bus.m_axis_ready;
            m_valid_s = bus.s_axis_valid;
            m_sop_s   = bus.s_axis_valid && (byte_cnt_r == 8'd0);
            m_last_s  = bus.s_axis_valid && (byte_cnt_r == DATA_LAST_IDX);
         end
         ST_PARITY: begin
            s_ready_s = 1'b1;
         end
         ST_STATUS: begin
            st_valid_s = 1'b1;
         end
         default: begin
            s_ready_s  = 1'b0;
            st_valid_s = 1'b0;
         end
      endcase
   end

   // Byte counter, syndrome accumulators and length-error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_r <= 8'd0;
         syn_r      <= '0;
         len_err_r  <= 1'b0;
      end else if (st_hs_s) begin
         byte_cnt_r <= 8'd0;
         syn_r      <= '0;
         len_err_r  <= 1'b0;
      end else if (accept_s) begin
         byte_cnt_r <= (byte_cnt_r == CW_LAST_IDX) ? byte_cnt_r : byte_cnt_r + 8'd1;
         syn_r      <= syn_next_s;
         if (bus.s_axis_last != (byte_cnt_r == CW_LAST_IDX)) begin
            len_err_r <= 1'b1;
         end else begin
            len_err_r <= len_err_r;
         end
      end else begin
         byte_cnt_r <= byte_cnt_r;
         syn_r      <= syn_r;
         len_err_r  <= len_err_r;
      end
   end

   assign bus.s_axis_ready = s_ready_s;
   assign bus.m_axis_valid = m_valid_s;
   assign bus.m_axis_data  = bus.s_axis_data;
   assign bus.m_axis_sop   = m_sop_s;
   assign bus.m_axis_last  = m_last_s;
   assign bus.st_valid     = st_valid_s;
   assign bus.st_err       = |syn_r;
   assign bus.st_len_err   = len_err_r;
   assign bus.st_syndromes = syn_r;

`ifdef ASSERT_ON
   rs_syndrome_checker_sva u_sva (
      .clk          (clk),
      .rst_n        (rst_n),
      .st_valid     (st_valid_s),
      .st_ready     (bus.st_ready),
      .st_err       (bus.st_err),
      .st_len_err   (len_err_r),
      .st_syndromes (syn_r)
   );
`endif

endmodule

`ifdef ASSERT_ON
module rs_syndrome_checker_sva (
   input logic         clk,
   input logic         rst_n,
   input logic         st_valid,
   input logic         st_ready,
   input logic         st_err,
   input logic         st_len_err,
   input logic [255:0] st_syndromes
);
   // A stalled status word must not change until it is taken
   a_st_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (st_valid && !st_ready) |=> (st_valid && $stable(st_err) && $stable(st_len_err)
                                   && $stable(st_syndromes)));
endmodule
`endif
